// File: rtl/mem_arbiter_if.sv
// Request/response bundle between IF, LSB, the arbiter and the memory controller.
// slave is the arbiter's view; master is the requester/controller side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              lsb_req;
  logic              lsb_we;
  logic [1:0]        lsb_len;
  logic [ADDR_W-1:0] lsb_addr;
  logic [DATA_W-1:0] lsb_wdata;
  logic              lsb_done;
  logic [DATA_W-1:0] lsb_rdata;
  logic              io_buffer_full;
  logic              mc_valid;
  logic              mc_we;
  logic [1:0]        mc_len;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_done;
  logic [DATA_W-1:0] mc_rdata;

  modport slave (
    input  if_req, if_addr,
    input  lsb_req, lsb_we, lsb_len, lsb_addr, lsb_wdata,
    input  io_buffer_full, mc_done, mc_rdata,
    output if_done, if_rdata, lsb_done, lsb_rdata,
    output mc_valid, mc_we, mc_len, mc_addr, mc_wdata
  );

  modport master (
    output if_req, if_addr,
    output lsb_req, lsb_we, lsb_len, lsb_addr, lsb_wdata,
    output io_buffer_full, mc_done, mc_rdata,
    input  if_done, if_rdata, lsb_done, lsb_rdata,
    input  mc_valid, mc_we, mc_len, mc_addr, mc_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// IF/LSB arbiter for the byte-serial memory controller port, LSB-first with IF anti-starvation.
// Optional IO_STALL_EN: IO-space stores wait while the UART output buffer is full.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  output logic         busy,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    GNT_LSB,
    GNT_IF,
    DRAIN
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mc_valid_q, mc_valid_d;
  logic              mc_we_q, mc_we_d;
  logic [1:0]        mc_len_q, mc_len_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [DATA_W-1:0] mc_wdata_q, mc_wdata_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              lsb_done_q, lsb_done_d;
  logic [DATA_W-1:0] lsb_rdata_q, lsb_rdata_d;
  logic [DATA_W-1:0] ld_mask;
  logic              lsb_go;

`ifdef IO_STALL_EN
  assign lsb_go = bus.lsb_req &&
                  !(bus.lsb_we && bus.lsb_addr[17:16] == 2'b11 &&
                    bus.io_buffer_full);
`else
  logic unused_io;
  assign lsb_go    = bus.lsb_req;
  assign unused_io = bus.io_buffer_full;
`endif

  always_comb begin
    ld_mask = '1;
    unique case (mc_len_q)
      2'b01:   ld_mask = DATA_W'(8'hFF);
      2'b10:   ld_mask = DATA_W'(16'hFFFF);
      default: ld_mask = '1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mc_valid_d  = mc_valid_q;
    mc_we_d     = mc_we_q;
    mc_len_d    = mc_len_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    if_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (lsb_go && (!bus.if_req || starve_q < LIMIT)) begin
          mc_valid_d = 1'b1;
          mc_we_d    = bus.lsb_we;
          mc_len_d   = bus.lsb_len;
          mc_addr_d  = bus.lsb_addr;
          mc_wdata_d = bus.lsb_wdata;
          state_d    = GNT_LSB;
          if (bus.if_req && starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
        end else if (bus.if_req && !flush_in) begin
          mc_valid_d = 1'b1;
          mc_we_d    = 1'b0;
          mc_len_d   = 2'b11;
          mc_addr_d  = bus.if_addr;
          starve_d   = '0;
          state_d    = GNT_IF;
        end
        if (!bus.if_req)
          starve_d = '0;
      end
      GNT_LSB: begin
        if (bus.mc_done) begin
          mc_valid_d  = 1'b0;
          lsb_done_d  = 1'b1;
          lsb_rdata_d = mc_we_q ? '0 : (bus.mc_rdata & ld_mask);
          state_d     = IDLE;
        end
      end
      GNT_IF: begin
        // A flush never aborts the controller; it only drops the result.
        if (bus.mc_done) begin
          mc_valid_d = 1'b0;
          state_d    = IDLE;
          if (!flush_in) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mc_rdata;
          end
        end else if (flush_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mc_done) begin
          mc_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mc_valid_q  <= 1'b0;
      mc_we_q     <= 1'b0;
      mc_len_q    <= '0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mc_valid_q  <= mc_valid_d;
      mc_we_q     <= mc_we_d;
      mc_len_q    <= mc_len_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.mc_valid  = mc_valid_q;
  assign bus.mc_we     = mc_we_q;
  assign bus.mc_len    = mc_len_q;
  assign bus.mc_addr   = mc_addr_q;
  assign bus.mc_wdata  = mc_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/dones are queued by the
// stimulus and popped by a negedge monitor; a model controller answers grants.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  len;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic        lsb;
    logic [31:0] data;
  } done_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic flush;
  logic busy;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .flush_in(flush),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  gnt_t  gq[$];
  done_t dq[$];
  int    auto_dly  = 3;
  logic [31:0] auto_data = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // model memory controller: answers each grant auto_dly cycles later
  initial begin
    bus.mc_done  = 1'b0;
    bus.mc_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mc_valid && !bus.mc_done) begin
        repeat (auto_dly - 1) @(negedge clk);
        bus.mc_done  = 1'b1;
        bus.mc_rdata = auto_data;
        @(negedge clk);
        bus.mc_done  = 1'b0;
      end
    end
  end

  // monitor: compares every grant and every done pulse against the queues
  initial begin
    logic  prev_v;
    gnt_t  g;
    done_t d;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mc_valid && !prev_v) begin
        chk("grant_expected", 32'(gq.size() != 0), 32'd1);
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("gnt_addr", bus.mc_addr, g.addr);
          chk("gnt_we", 32'(bus.mc_we), 32'(g.we));
          chk("gnt_len", 32'(bus.mc_len), 32'(g.len));
          if (g.we) chk("gnt_wdata", bus.mc_wdata, g.wdata);
        end
      end
      if (bus.if_done || bus.lsb_done) begin
        chk("done_onehot", 32'(bus.if_done && bus.lsb_done), 32'd0);
        chk("done_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          d = dq.pop_front();
          chk("done_src", 32'(bus.lsb_done), 32'(d.lsb));
          chk("done_data", bus.lsb_done ? bus.lsb_rdata : bus.if_rdata,
              d.data);
        end
      end
      prev_v = bus.mc_valid;
    end
  end

  task automatic wait_dones(int n, int budget, bit drop);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (bus.if_done || bus.lsb_done) seen++;
      if (drop && bus.if_done) bus.if_req = 1'b0;
      if (drop && bus.lsb_done) bus.lsb_req = 1'b0;
    end
    chk("done_count", 32'(seen), 32'(n));
  endtask

  task automatic lsb_op(logic [31:0] a, logic we, logic [1:0] len,
                        logic [31:0] wd, logic [31:0] exp);
    gq.push_back('{a, we, len, wd});
    dq.push_back('{1'b1, exp});
    @(negedge clk);
    bus.lsb_addr  = a;
    bus.lsb_we    = we;
    bus.lsb_len   = len;
    bus.lsb_wdata = wd;
    bus.lsb_req   = 1'b1;
    wait_dones(1, 40, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    flush = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.lsb_req = 1'b0;
    bus.lsb_we = 1'b0;
    bus.lsb_len = 2'b00;
    bus.lsb_addr = '0;
    bus.lsb_wdata = '0;
    bus.io_buffer_full = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_mc_valid", 32'(bus.mc_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_if_done", 32'(bus.if_done), 32'd0);
    chk("rst_lsb_done", 32'(bus.lsb_done), 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'd0);
    chk("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    rst_n = 1'b1;

    // single fetch
    auto_dly  = 5;
    auto_data = 32'h00C5_0513;
    gq.push_back('{32'h100, 1'b0, 2'b11, 32'h0});
    dq.push_back('{1'b0, 32'h00C5_0513});
    @(negedge clk);
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("if_latency", 32'(bus.mc_valid), 32'd1);
    chk("if_busy", 32'(busy), 32'd1);
    wait_dones(1, 30, 1'b1);
    chk("if_busy_fall", 32'(busy), 32'd0);

    // loads of each width and a store
    auto_dly  = 3;
    auto_data = 32'hDEAD_BEEF;
    lsb_op(32'h200, 1'b0, 2'b01, 32'h0, 32'h0000_00EF);
    lsb_op(32'h204, 1'b0, 2'b10, 32'h0, 32'h0000_BEEF);
    lsb_op(32'h208, 1'b1, 2'b11, 32'hCAFE_F00D, 32'h0);

    // starvation: LSB x4 then IF then LSB
    auto_data = 32'h1111_1111;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) gq.push_back('{32'h400, 1'b0, 2'b11, 32'h0});
      else        gq.push_back('{32'h300, 1'b0, 2'b11, 32'h0});
      dq.push_back('{(i != 4), 32'h1111_1111});
    end
    @(negedge clk);
    bus.lsb_addr = 32'h300;
    bus.lsb_we   = 1'b0;
    bus.lsb_len  = 2'b11;
    bus.if_addr  = 32'h400;
    bus.lsb_req  = 1'b1;
    bus.if_req   = 1'b1;
    wait_dones(6, 200, 1'b0);
    bus.lsb_req = 1'b0;
    bus.if_req  = 1'b0;

    // flush mid-fetch, drained by the controller
    auto_dly  = 5;
    auto_data = 32'h5555_5555;
    gq.push_back('{32'h500, 1'b0, 2'b11, 32'h0});
    @(negedge clk);
    bus.if_addr = 32'h500;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("fl_grant", 32'(bus.mc_valid), 32'd1);
    @(negedge clk);
    flush      = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_drain_valid", 32'(bus.mc_valid), 32'd1);
    chk("fl_drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("fl_hold_valid", 32'(bus.mc_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("fl_end_valid", 32'(bus.mc_valid), 32'd0);
    chk("fl_end_busy", 32'(busy), 32'd0);
    chk("fl_no_if_done", 32'(bus.if_done), 32'd0);
    // back-to-back fetch, flush coincides with mc_done
    auto_dly = 2;
    gq.push_back('{32'h600, 1'b0, 2'b11, 32'h0});
    bus.if_addr = 32'h600;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("fl_regrant", 32'(bus.mc_valid), 32'd1);
    @(negedge clk);
    flush      = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fl2_valid", 32'(bus.mc_valid), 32'd0);
    chk("fl2_no_if_done", 32'(bus.if_done), 32'd0);
    chk("fl2_busy", 32'(busy), 32'd0);

    // rdy_in low swallows an mc_done
    auto_data = 32'h1234_5678;
    gq.push_back('{32'h700, 1'b0, 2'b11, 32'h0});
    dq.push_back('{1'b1, 32'h1234_5678});
    @(negedge clk);
    bus.lsb_addr = 32'h700;
    bus.lsb_we   = 1'b0;
    bus.lsb_len  = 2'b11;
    bus.lsb_req  = 1'b1;
    @(negedge clk);
    chk("rdy_grant", 32'(bus.mc_valid), 32'd1);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rdy_valid_held", 32'(bus.mc_valid), 32'd1);
    chk("rdy_busy_held", 32'(busy), 32'd1);
    chk("rdy_no_done", 32'(bus.lsb_done), 32'd0);
    rdy = 1'b1;
    wait_dones(1, 20, 1'b1);

    // asynchronous reset mid-transaction
    auto_dly = 10;
    gq.push_back('{32'h800, 1'b1, 2'b11, 32'h0BAD_CAFE});
    @(negedge clk);
    bus.lsb_addr  = 32'h800;
    bus.lsb_we    = 1'b1;
    bus.lsb_wdata = 32'h0BAD_CAFE;
    bus.lsb_req   = 1'b1;
    @(negedge clk);
    chk("ar_grant", 32'(bus.mc_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.mc_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_addr", bus.mc_addr, 32'd0);
    chk("ar_wdata", bus.mc_wdata, 32'd0);
    bus.lsb_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("ar_idle_busy", 32'(busy), 32'd0);

    // IO store vs full UART buffer
    auto_dly  = 3;
    auto_data = 32'hA5A5_A5A5;
`ifdef IO_STALL_EN
    gq.push_back('{32'h900, 1'b0, 2'b11, 32'h0});
    gq.push_back('{32'h3_0000, 1'b1, 2'b01, 32'h41});
    dq.push_back('{1'b0, 32'hA5A5_A5A5});
    dq.push_back('{1'b1, 32'h0});
`else
    gq.push_back('{32'h3_0000, 1'b1, 2'b01, 32'h41});
    gq.push_back('{32'h900, 1'b0, 2'b11, 32'h0});
    dq.push_back('{1'b1, 32'h0});
    dq.push_back('{1'b0, 32'hA5A5_A5A5});
`endif
    @(negedge clk);
    bus.io_buffer_full = 1'b1;
    bus.lsb_addr  = 32'h3_0000;
    bus.lsb_we    = 1'b1;
    bus.lsb_len   = 2'b01;
    bus.lsb_wdata = 32'h41;
    bus.if_addr   = 32'h900;
    bus.lsb_req   = 1'b1;
    bus.if_req    = 1'b1;
    repeat (2) @(negedge clk);
    bus.io_buffer_full = 1'b0;
    wait_dones(2, 60, 1'b1);

    repeat (4) @(negedge clk);
    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Schedules the single byte-serial memory controller port between two requesters: instruction fetch (IF) and load/store buffer (LSB).
- Sits between the IF/LSB units and the memory controller; owns grant policy, request latching, flush cancellation and done routing.
- LSB has default priority; a starvation counter bounds IF wait time.
- Exactly one transaction is outstanding at the memory controller at any time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive LSB grants with IF pending before IF is forced to win (range 1..15)

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous reset, active-low
- rdy_in  input  1  global enable; low freezes all state
- flush_in  input  1  pipeline flush (branch mispredict); cancels IF traffic
- if_req  input  1  IF request, level-held until if_done or flush
- if_addr  input  ADDR_W  fetch address
- if_done  output  1  one-cycle pulse, if_rdata valid
- if_rdata  output  DATA_W  fetched instruction
- lsb_req  input  1  LSB request, level-held until lsb_done
- lsb_we  input  1  1 = store, 0 = load
- lsb_len  input  2  bytes: 01=1, 10=2, 11=4
- lsb_addr  input  ADDR_W  access address
- lsb_wdata  input  DATA_W  store data
- lsb_done  output  1  one-cycle pulse; lsb_rdata valid for loads
- lsb_rdata  output  DATA_W  load result, zero-extended
- io_buffer_full  input  1  UART output buffer full
- mc_valid  output  1  transaction request to memory controller
- mc_we  output  1  store flag
- mc_len  output  2  byte count code
- mc_addr  output  ADDR_W  address
- mc_wdata  output  DATA_W  store data
- mc_done  input  1  one-cycle completion from memory controller
- mc_rdata  input  DATA_W  read data, valid with mc_done
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n_in low, asynchronous): state=IDLE, starve_cnt=0. All outputs 0.
- rdy_in low: no state, counter or output register changes; mc_done/flush_in ignored that cycle.
- States: IDLE, GNT_LSB, GNT_IF, DRAIN.
- IDLE grant decision, evaluated each cycle:
  - If lsb_req and (!if_req or starve_cnt<STARVE_LIMIT): latch LSB fields into mc_*, mc_valid<=1, go to GNT_LSB. If if_req is pending, starve_cnt++ (saturating).
  - Else if if_req and !flush_in: latch mc_addr=if_addr, mc_we=0, mc_len=11, mc_valid<=1, starve_cnt<=0, go to GNT_IF.
  - Else remain in IDLE.
- A request seen in IDLE at cycle N gives mc_valid=1 at N+1. mc_* are held stable while mc_valid=1.
- GNT_LSB: on mc_done, drive mc_valid<=0 and lsb_done<=1 for 1 cycle. For loads, set lsb_rdata from mc_rdata masked by len (len 01 keeps [7:0], 10 keeps [15:8..0], upper bits 0). For stores, lsb_rdata=0. Go to IDLE. flush_in has no effect on an LSB transaction.
- GNT_IF: on mc_done without flush, drive if_done<=1 and if_rdata<=mc_rdata, then go to IDLE. If flush_in arrives before mc_done, go to DRAIN with mc_valid still held. If flush_in and mc_done occur in the same cycle, the data is discarded, no if_done is issued, and the state goes to IDLE.
- DRAIN: wait for mc_done, then mc_valid<=0, no if_done, go to IDLE. A transaction already started at the controller is never aborted.
- The earliest new grant is the cycle after done, giving 1 idle cycle between transactions.
- mc_done in IDLE is ignored. if_done and lsb_done are never both high.
- starve_cnt is cleared whenever if_req is low in IDLE.

Optional Feature:
- Macro IO_STALL_EN.
- Defined: an LSB store with lsb_addr[17:16]==2'b11 (IO space, ≥0x30000) is not granted while io_buffer_full=1. IF may be granted instead, and starve_cnt is not incremented for that cycle. Once granted, the store is unaffected by io_buffer_full.
- Undefined: io_buffer_full is ignored; IO stores arbitrate like any store.

Test Plan:
- Single IF: if_req=1, if_addr=0x0000_0100, and mc_done is returned 5 cycles after mc_valid with mc_rdata=0x00C5_0513 -> mc_addr=0x100, mc_len=11, mc_we=0; one if_done pulse with if_rdata=0x00C5_0513; busy falls the next cycle.
- Priority/starvation: if_req and lsb_req held high continuously, STARVE_LIMIT=4, each mc_done returned 3 cycles after issue -> grant order LSB, LSB, LSB, LSB, IF, LSB…
- Byte load: lsb_req, lsb_we=0, lsb_len=01, addr 0x200, mc_rdata=0xDEAD_BEEF -> lsb_rdata=0x0000_00EF with a single lsb_done.
- Flush mid-fetch: IF granted, flush_in pulsed 2 cycles later, mc_done 3 cycles after that -> no if_done; mc_valid held until mc_done; next grant possible the following cycle. Repeat with flush_in and mc_done in the same cycle -> no if_done.
- rdy_in/reset: rdy_in low for 3 cycles during GNT_LSB with mc_done asserted in one of those cycles -> state unchanged, no lsb_done. Assert rst_n_in low mid-transaction -> all outputs 0 immediately, without waiting for a clock edge.
- IO_STALL_EN: store to 0x0003_0000 with io_buffer_full=1 and if_req=1 -> IF granted, store held; after io_buffer_full=0 -> store granted. Without the macro, the store is granted first.
